// File: rtl/vga_timing_pkg.sv
`default_nettype none
// ============================================================================
//  Module      : vga_timing_pkg
//  Description : Shared VGA timing constants for the 640x480@60 scan
//                generator: default porch/sync widths, derived totals,
//                sync window bounds and the coordinate width.
//  Revision    : 1.0 - initial release
// ============================================================================
package vga_timing_pkg;

    // Width of the column/line counters and coordinate outputs.
    localparam int c_coord_w       = 10;

    // Horizontal timing in pixels.
    localparam int c_h_active      = 640;
    localparam int c_h_fp          = 16;
    localparam int c_h_sync        = 96;
    localparam int c_h_bp          = 48;
    localparam int c_h_total       = c_h_active + c_h_fp + c_h_sync + c_h_bp;
    localparam int c_h_sync_start  = c_h_active + c_h_fp;
    localparam int c_h_sync_end    = c_h_sync_start + c_h_sync - 1;

    // Vertical timing in lines.
    localparam int c_v_active      = 480;
    localparam int c_v_fp          = 10;
    localparam int c_v_sync        = 2;
    localparam int c_v_bp          = 33;
    localparam int c_v_total       = c_v_active + c_v_fp + c_v_sync + c_v_bp;
    localparam int c_v_sync_start  = c_v_active + c_v_fp;
    localparam int c_v_sync_end    = c_v_sync_start + c_v_sync - 1;

endpackage
`default_nettype wire

// File: rtl/clk_en_div.sv
`default_nettype none
// ============================================================================
//  Module      : clk_en_div
//  Description : Pixel-enable divider. Produces a registered one-clk tick
//                once every CLK_DIV clk cycles; with CLK_DIV=1 the tick is
//                high on every cycle out of reset.
//  Revision    : 1.0 - initial release
// ============================================================================
module clk_en_div #(
    parameter int CLK_DIV = 2
) (
    input  logic clk,
    input  logic rst,
    output logic tick
);

    localparam int                   c_phase_w = (CLK_DIV > 1) ? $clog2(CLK_DIV) : 1;
    localparam logic [c_phase_w-1:0] c_last    = c_phase_w'(CLK_DIV - 1);

    logic [c_phase_w-1:0] r_phase;
    logic                 r_tick;

    // Phase counter wraps at CLK_DIV-1; the tick register fires on that phase.
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            r_phase <= '0;
            r_tick  <= 1'b0;
        end else begin
            r_tick <= (r_phase == c_last);
            if (r_phase == c_last) begin
                r_phase <= '0;
            end else begin
                r_phase <= r_phase + c_phase_w'(1);
            end
        end
    end

    assign tick = r_tick;

endmodule
`default_nettype wire

// File: rtl/vga_scan_gen.sv
`default_nettype none
// ============================================================================
//  Module      : vga_scan_gen
//  Description : VGA raster scan generator. Column/line counters advance on
//                the pixel tick; sync, blanking and the frame-update pulse
//                are decoded from the next-state counter values and
//                registered so they align with the counters.
//  Revision    : 1.0 - initial release
// ============================================================================
module vga_scan_gen
    import vga_timing_pkg::*;
#(
    parameter int CLK_DIV  = 2,
    parameter int H_ACTIVE = c_h_active,
    parameter int H_FP     = c_h_fp,
    parameter int H_SYNC   = c_h_sync,
    parameter int H_BP     = c_h_bp,
    parameter int V_ACTIVE = c_v_active,
    parameter int V_FP     = c_v_fp,
    parameter int V_SYNC   = c_v_sync,
    parameter int V_BP     = c_v_bp
) (
    input  logic                 clk,
    input  logic                 rst,
    output logic                 pixTick,
    output logic [c_coord_w-1:0] xLength,
    output logic [c_coord_w-1:0] yLength,
    output logic                 hsync,
    output logic                 vsync,
    output logic                 videoOn,
    output logic                 update
);

    localparam logic [c_coord_w-1:0] c_x_last   = c_coord_w'(H_ACTIVE + H_FP + H_SYNC + H_BP - 1);
    localparam logic [c_coord_w-1:0] c_y_last   = c_coord_w'(V_ACTIVE + V_FP + V_SYNC + V_BP - 1);
    localparam logic [c_coord_w-1:0] c_x_act    = c_coord_w'(H_ACTIVE);
    localparam logic [c_coord_w-1:0] c_y_act    = c_coord_w'(V_ACTIVE);
    localparam logic [c_coord_w-1:0] c_hs_start = c_coord_w'(H_ACTIVE + H_FP);
    localparam logic [c_coord_w-1:0] c_hs_end   = c_coord_w'(H_ACTIVE + H_FP + H_SYNC - 1);
    localparam logic [c_coord_w-1:0] c_vs_start = c_coord_w'(V_ACTIVE + V_FP);
    localparam logic [c_coord_w-1:0] c_vs_end   = c_coord_w'(V_ACTIVE + V_FP + V_SYNC - 1);

    logic                 w_tick;
    logic [c_coord_w-1:0] w_x_next;
    logic [c_coord_w-1:0] w_y_next;
    logic [c_coord_w-1:0] r_x;
    logic [c_coord_w-1:0] r_y;
    logic                 r_hsync;
    logic                 r_vsync;
    logic                 r_video;
    logic                 r_update;

    clk_en_div #(
        .CLK_DIV (CLK_DIV)
    ) u_div (
        .clk  (clk),
        .rst  (rst),
        .tick (w_tick)
    );

    // Next raster position: step the column on a tick, step the line on a column wrap.
    always_comb begin
        w_x_next = r_x;
        w_y_next = r_y;
        if (w_tick) begin
            if (r_x == c_x_last) begin
                w_x_next = '0;
                if (r_y == c_y_last) begin
                    w_y_next = '0;
                end else begin
                    w_y_next = r_y + c_coord_w'(1);
                end
            end else begin
                w_x_next = r_x + c_coord_w'(1);
            end
        end
    end

    // Counters plus decodes of the next position, so every output moves on the same edge.
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            r_x      <= '0;
            r_y      <= '0;
            r_hsync  <= 1'b1;
            r_vsync  <= 1'b1;
            r_video  <= 1'b1;
            r_update <= 1'b0;
        end else begin
            r_x      <= w_x_next;
            r_y      <= w_y_next;
            r_hsync  <= !((w_x_next >= c_hs_start) && (w_x_next <= c_hs_end));
            r_vsync  <= !((w_y_next >= c_vs_start) && (w_y_next <= c_vs_end));
            r_video  <= (w_x_next < c_x_act) && (w_y_next < c_y_act);
            // Only the moving edge into the first blanking line qualifies.
            r_update <= w_tick && (w_x_next == '0) && (w_y_next == c_y_act);
        end
    end

    assign pixTick = w_tick;
    assign xLength = r_x;
    assign yLength = r_y;
    assign hsync   = r_hsync;
    assign vsync   = r_vsync;
    assign videoOn = r_video;
    assign update  = r_update;

endmodule
`default_nettype wire

// File: doc/vga_scan_gen.md
VGA_SCAN_GEN -- requirements
Module: vga_scan_gen

Interface
REQ-001 The block SHALL have one clock and SHALL use an asynchronous, active-low reset.
REQ-002 Parameter CLK_DIV, default 2: number of clk cycles per pixel.
REQ-003 Parameter H_ACTIVE/H_FP/H_SYNC/H_BP, defaults 640/16/96/48: horizontal timing in pixels.
REQ-004 Parameter V_ACTIVE/V_FP/V_SYNC/V_BP, defaults 480/10/2/33: vertical timing in lines.
REQ-005 Port clk, input, 1: system clock, 50 MHz nominal.
REQ-006 Port rst, input, 1: asynchronous active-low reset.
REQ-007 Port pixTick, output, 1: one-clk pulse per pixel period.
REQ-008 Port xLength, output, 10: current column, 0..H_TOTAL-1, where H_TOTAL is 800 by default.
REQ-009 Port yLength, output, 10: current line, 0..V_TOTAL-1, where V_TOTAL is 525 by default.
REQ-010 Port hsync, output, 1: horizontal sync, active low.
REQ-011 Port vsync, output, 1: vertical sync, active low.
REQ-012 Port videoOn, output, 1: high while (xLength, yLength) is inside the active area.
REQ-013 Port update, output, 1: frame tick, one-clk pulse at the start of vertical blank.

Function
REQ-014 The divider SHALL assert pixTick for exactly one clk cycle in every CLK_DIV cycles: on the cycle its phase counter equals CLK_DIV-1.
REQ-015 When CLK_DIV=1, pixTick SHALL be high every cycle.
REQ-016 xLength SHALL advance only on a clk edge where pixTick is high.
  - Increment by 1 when xLength < H_TOTAL-1.
  - Wrap to 0 when xLength = H_TOTAL-1.
REQ-017 yLength SHALL change only on an xLength wrap.
  - Increment by 1 when yLength < V_TOTAL-1.
  - Wrap to 0 when yLength = V_TOTAL-1.
  - Both counters wrap on the same edge at (799,524) -> (0,0).
REQ-018 hsync SHALL be 0 exactly when xLength is in [H_ACTIVE+H_FP, H_ACTIVE+H_FP+H_SYNC-1] = [656,751]; otherwise 1.
REQ-019 vsync SHALL be 0 exactly when yLength is in [V_ACTIVE+V_FP, V_ACTIVE+V_FP+V_SYNC-1] = [490,491]; otherwise 1.
REQ-020 videoOn SHALL be 1 exactly when xLength < H_ACTIVE and yLength < V_ACTIVE.
REQ-021 hsync, vsync and videoOn SHALL be registered and decoded from next-state counter values, so they change on the same clk edge as the counters (zero cycles of skew relative to xLength/yLength).
REQ-022 update SHALL pulse high for exactly one clk cycle: the edge on which the counters move to (0, V_ACTIVE) = (0,480).
REQ-023 update SHALL occur exactly once per frame (every 800*525*CLK_DIV clk cycles).
REQ-024 All outputs SHALL be glitch-free register outputs; no combinational path from any input to any output.
REQ-025 Counter arithmetic SHALL be 10-bit unsigned; no counter value outside its range SHALL ever be reached.

Reset
REQ-026 While rst=0, independent of clk, the block SHALL hold these values:
  - divider phase = 0
  - xLength = 0, yLength = 0
  - pixTick = 0, update = 0
  - hsync = 1, vsync = 1
  - videoOn = 1 (the decode of position 0,0)
REQ-027 After rst deasserts, the first pixTick SHALL occur CLK_DIV clk edges later, and the counters SHALL then step to (1,0).
REQ-028 Reset asserted mid-frame SHALL immediately return all state to the REQ-026 values, with no partial-frame completion.

Structure
REQ-029 A shared package vga_timing_pkg SHALL hold:
  - default H/V timing constants
  - derived H_TOTAL, V_TOTAL, sync start/end
  - the 10-bit coordinate width
REQ-030 Pixel-enable generation SHALL be a sub-module clk_en_div (parameter CLK_DIV; ports clk, rst, tick).
REQ-031 The remaining logic (counters, sync/blank decode, update) SHALL live in vga_scan_gen.

Verification
REQ-032 Reset and first tick: hold rst=0 for 5 clk, release -> outputs at REQ-026 values; pixTick first high on clk edge 2; xLength=1 after it.
REQ-033 Line wrap: run to xLength=799, yLength=10 -> next pixTick gives xLength=0, yLength=11; hsync low for exactly 96 pixels (656..751) of that line.
REQ-034 Frame wrap and update: run a full frame ->
  - update high for exactly 1 clk, at (0,480)
  - vsync low for lines 490..491 only
  - (799,524) -> (0,0)
  - 420000 pixTicks (840000 clk cycles) between successive update pulses
REQ-035 Active area: across a frame, videoOn high for exactly 640*480 = 307200 pixel periods; low at (640,0) and at (0,480).
REQ-036 Mid-frame reset: assert rst=0 at (300,200) for 3 clk -> counters 0,0 immediately (asynchronously), no update pulse; normal counting resumes after release.
REQ-037 Parameter sweep: CLK_DIV=1 -> pixTick constant 1, frame length 420000 clk; CLK_DIV=4 -> pixTick 1-in-4, frame length 1680000 clk.
